// File: rtl/divide_sequencer.sv
// rtl/divide_sequencer.sv - Multi-cycle restoring divider for DIV/DIVU/REM/REMU with flush and async reset.
module divide_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [5:0]       count;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;

    logic             accept;
    logic             is_signed;
    logic             is_rem;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        accept    = START && (SELECT[4:2] == 3'b011);
        is_signed = ~SELECT[0];
        is_rem    = SELECT[1];
        a_neg     = is_signed & DATA1[WIDTH-1];
        b_neg     = is_signed & DATA2[WIDTH-1];
        a_mag     = a_neg ? (~DATA1 + 1'b1) : DATA1;
        b_mag     = b_neg ? (~DATA2 + 1'b1) : DATA2;
        div_zero  = (DATA2 == '0);
        overflow  = is_signed && (DATA1 == MIN_NEG) && (DATA2 == '1);
        // Partial remainder is always below 2*divisor, so bit WIDTH of diff is a clean borrow flag.
        shifted   = {rem, dvd[WIDTH-1]};
        diff      = shifted - {1'b0, dvs};
        no_borrow = ~diff[WIDTH];
        q_fix     = neg_q ? (~dvd + 1'b1) : dvd;
        r_fix     = neg_r ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            count  <= '0;
            op_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            BUSY   <= 1'b0;
            VALID  <= 1'b0;
            RESULT <= '0;
        end else if (FLUSH) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            VALID <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    VALID <= 1'b0;
                    if (accept) begin
                        op_rem <= is_rem;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dvd    <= a_mag;
                        dvs    <= b_mag;
                        rem    <= '0;
                        count  <= '0;
                        BUSY   <= 1'b1;
                        if (div_zero) begin
                            state  <= DONE;
                            VALID  <= 1'b1;
                            RESULT <= is_rem ? DATA1 : '1;
                        end else if (overflow) begin
                            state  <= DONE;
                            VALID  <= 1'b1;
                            RESULT <= is_rem ? '0 : MIN_NEG;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // Steps run at count 0..WIDTH-1; the extra cycle applies the sign fix from registers.
                    if (count == 6'(WIDTH)) begin
                        state  <= DONE;
                        VALID  <= 1'b1;
                        RESULT <= op_rem ? r_fix : q_fix;
                    end else begin
                        rem   <= no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dvd   <= {dvd[WIDTH-2:0], no_borrow};
                        count <= count + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// tb/tb_divide_sequencer.sv - Directed and random checks of divide_sequencer results, latency, flush and reset.
module tb_divide_sequencer;

    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_REM  = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  sel;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        flush;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;
    int n;
    int busy_cnt;

    divide_sequencer #(.WIDTH(32)) dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .SELECT(sel),
        .DATA1(data1), .DATA2(data2), .FLUSH(flush),
        .BUSY(busy), .VALID(valid), .RESULT(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
        if (busy && !valid) busy_cnt++;
    endtask

    // Presents a request at a negedge; returns at the negedge after the accepting edge with n = 1.
    task automatic issue(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        sel = s; data1 = a; data2 = b; start = 1'b1;
        n = 0; busy_cnt = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (valid) begin lat = n; break; end
            tick();
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        issue(s, a, b);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_res);
        tick();
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (valid) seen++;
            tick();
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] ref_model(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (s)
            OP_DIV:  ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            OP_DIVU: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:  ref_model = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: ref_model = (b == 0) ? a : a % b;
        endcase
    endfunction

    initial begin
        int lat;
        logic [4:0]  rs;
        logic [31:0] ra;
        logic [31:0] rb;
        int          el;

        rst_n = 1'b0; start = 1'b0; sel = 5'd0; data1 = '0; data2 = '0; flush = 1'b0;
        n = 0; busy_cnt = 0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Unsupported op code must not start anything.
        issue(5'b00000, 32'd100, 32'd7);
        check("bad_select_busy", {31'd0, busy}, 32'd0);
        tick();

        issue(OP_DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        check("divu_latency", 32'(lat), 32'd34);
        check("divu_result", result, 32'd14);
        check("divu_busy_cycles", 32'(busy_cnt), 32'd33);
        tick();
        check("divu_valid_one_cycle", {31'd0, valid}, 32'd0);
        check("divu_result_hold", result, 32'd14);

        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("div_by_zero", OP_DIV, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by_zero", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1);
        run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

        // Second START during CALC is ignored.
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) tick();
        sel = OP_DIV; data1 = 32'd999; data2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        check("restart_ignored_latency", 32'(lat), 32'd34);
        check("restart_ignored_result", result, 32'd14);
        tick();
        check("restart_no_second_op", {31'd0, busy}, 32'd0);

        // FLUSH on CALC cycle 10, with START in the same cycle losing to FLUSH.
        issue(OP_DIVU, 32'd1000, 32'd3);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1; start = 1'b1; sel = OP_DIVU; data1 = 32'd50; data2 = 32'd5;
        tick();
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result_hold", result, 32'd14);
        no_valid_for("flush_no_valid", 36);
        check("flush_result_still", result, 32'd14);
        run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);

        // Asynchronous reset in the middle of CALC.
        issue(OP_REMU, 32'd1000, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_valid", {31'd0, valid}, 32'd0);
        check("async_rst_result", result, 32'd0);
        tick();
        rst_n = 1'b1;
        no_valid_for("post_reset_no_valid", 40);
        run_op("post_reset_op", OP_REMU, 32'd1000, 32'd7, 32'd6, 34);

        for (int k = 0; k < 1000; k++) begin
            case ($urandom_range(0, 3))
                0: rs = OP_DIV;
                1: rs = OP_DIVU;
                2: rs = OP_REM;
                default: rs = OP_REMU;
            endcase
            ra = $urandom();
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin rb = 32'hFFFF_FFFF; ra = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : ra; end
                2: rb = $urandom_range(1, 16);
                default: rb = $urandom();
            endcase
            el = ((rb == 0) || (!rs[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 34;
            run_op($sformatf("rand%0d", k), rs, ra, rb, ref_model(rs, ra, rb), el);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
